uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 135 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive FIFO between a serial receiver and an IO data register
//
// Purpose: captures bytes offered by a UART receiver via a level rxrdy/rxdone
// handshake and queues them for software reads through an IO read strobe.
//
// Ports:
//   clk     system clock, rising edge
//   rst     asynchronous active-low reset
//   rxrdy   byte-ready level from receiver, held until acknowledged
//   rxdata  received byte, valid while rxrdy=1
//   rxdone  one-cycle registered acknowledge to receiver
//   rd      IO read strobe of data register (may be held several cycles)
//   clr     IO write strobe of status register, clears ovf
//   data    byte at FIFO head, 8'h00 when empty
//   rdy     FIFO non-empty
//   count   bytes held, 0..DEPTH
//   ovf     sticky overflow flag
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rxrdy,
  input  logic [7:0]    rxdata,
  output logic          rxdone,
  input  logic          rd,
  input  logic          clr,
  output logic [7:0]    data,
  output logic          rdy,
  output logic [AW:0]   count,
  output logic          ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          rd_q;
  state_t        state;

  logic push_req;
  logic pop;
  logic push_ok;
  logic drop;

  // A capture is attempted only from IDLE, so a byte held on rxrdy through
  // ACK/WAIT is never taken twice.
  assign push_req = (state == S_IDLE) && rxrdy;
  // Rising edge of rd gives exactly one pop per strobe, however long it is held.
  assign pop      = rd && !rd_q && (cnt != '0);
  // When full, a push is still accepted if a pop frees the head slot this edge.
  assign push_ok  = push_req && ((cnt != FULL_CNT) || pop);
  assign drop     = push_req && !push_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      rxdone <= 1'b0;
      wp     <= '0;
      rp     <= '0;
      cnt    <= '0;
      rd_q   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      rd_q <= rd;

      case (state)
        S_IDLE: begin
          if (rxrdy) begin
            state  <= S_ACK;
            rxdone <= 1'b1;
          end else begin
            rxdone <= 1'b0;
          end
        end
        S_ACK: begin
          state  <= S_WAIT;
          rxdone <= 1'b0;
        end
        S_WAIT: begin
          rxdone <= 1'b0;
          if (!rxrdy) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state  <= S_IDLE;
          rxdone <= 1'b0;
        end
      endcase

      if (push_ok) begin
        wp <= wp + PTR_ONE;
      end
      if (pop) begin
        rp <= rp + PTR_ONE;
      end
      if (push_ok && !pop) begin
        cnt <= cnt + CNT_ONE;
      end else if (pop && !push_ok) begin
        cnt <= cnt - CNT_ONE;
      end

      // Set wins over clear when both happen on the same edge.
      if (drop) begin
        ovf <= 1'b1;
      end else if (clr) begin
        ovf <= 1'b0;
      end
    end
  end

  // Storage is not reset; unread slots are masked by the empty check below.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wp] <= rxdata;
    end
  end

  assign count = cnt;
  assign rdy   = (cnt != '0);
  assign data  = rdy ? mem[rp] : 8'h00;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst;
  logic       rxrdy;
  logic [7:0] rxdata;
  logic       rxdone;
  logic       rd;
  logic       clr;
  logic [7:0] data;
  logic       rdy;
  logic [4:0] count;
  logic       ovf;

  int checks;
  int errors;
  int pulses;
  logic rxdone_prev;
  logic dbl_pulse;

  uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .rxrdy  (rxrdy),
    .rxdata (rxdata),
    .rxdone (rxdone),
    .rd     (rd),
    .clr    (clr),
    .data   (data),
    .rdy    (rdy),
    .count  (count),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rxdone) pulses++;
    if (rxdone && rxdone_prev) dbl_pulse = 1'b1;
    rxdone_prev = rxdone;
  end

  typedef struct {
    logic       rxrdy;
    logic [7:0] rxdata;
    logic       rd;
    logic       clr;
    logic       e_rxdone;
    logic       e_rdy;
    logic [4:0] e_count;
    logic [7:0] e_data;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    logic seen;
    seen = 1'b0;
    rxrdy = 1'b1;
    rxdata = b;
    for (int k = 0; k < 4 && !seen; k++) begin
      step();
      if (rxdone) seen = 1'b1;
    end
    chk("push_ack", {31'd0, seen}, 32'd1);
    rxrdy = 1'b0;
    step();
    step();
  endtask

  task automatic pop_byte(input logic [7:0] exp);
    chk("pop_data", {24'd0, data}, {24'd0, exp});
    rd = 1'b1;
    step();
    rd = 1'b0;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pulses = 0;
    rxdone_prev = 1'b0;
    dbl_pulse = 1'b0;
    rst = 1'b0;
    rxrdy = 1'b0;
    rxdata = 8'h00;
    rd = 1'b0;
    clr = 1'b0;

    // rxrdy rxdata rd clr | rxdone rdy count data ovf
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 8'hA5, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 8'hA5, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 8'hA5, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0};
    vecs[7]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 8'h3C, 1'b0};
    vecs[8]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 8'h3C, 1'b0};
    vecs[9]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 8'h3C, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 8'h3C, 1'b0};
    vecs[11] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 8'h5A, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 8'h5A, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 8'h5A, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0};

    #2;
    chk("reset_rxdone", {31'd0, rxdone}, 32'd0);
    chk("reset_rdy",    {31'd0, rdy},    32'd0);
    chk("reset_count",  {27'd0, count},  32'd0);
    chk("reset_data",   {24'd0, data},   32'd0);
    chk("reset_ovf",    {31'd0, ovf},    32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("post_reset_count", {27'd0, count}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      rxrdy  = vecs[i].rxrdy;
      rxdata = vecs[i].rxdata;
      rd     = vecs[i].rd;
      clr    = vecs[i].clr;
      step();
      chk($sformatf("vec%0d_rxdone", i), {31'd0, rxdone}, {31'd0, vecs[i].e_rxdone});
      chk($sformatf("vec%0d_rdy", i),    {31'd0, rdy},    {31'd0, vecs[i].e_rdy});
      chk($sformatf("vec%0d_count", i),  {27'd0, count},  {27'd0, vecs[i].e_count});
      chk($sformatf("vec%0d_data", i),   {24'd0, data},   {24'd0, vecs[i].e_data});
      chk($sformatf("vec%0d_ovf", i),    {31'd0, ovf},    {31'd0, vecs[i].e_ovf});
    end
    rxrdy = 1'b0;
    rd = 1'b0;
    clr = 1'b0;

    // Fill and overflow
    pulses = 0;
    for (int i = 0; i < 17; i++) push_byte(8'(i));
    chk("fill_count",  {27'd0, count}, 32'd16);
    chk("fill_ovf",    {31'd0, ovf},   32'd1);
    chk("fill_pulses", pulses,         32'd17);
    for (int i = 0; i < 16; i++) pop_byte(8'(i));
    chk("drain_count", {27'd0, count}, 32'd0);
    chk("drain_data",  {24'd0, data},  32'd0);
    chk("ovf_sticky",  {31'd0, ovf},   32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_ovf", {31'd0, ovf}, 32'd0);

    // Long read strobe
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    chk("long_pre_count", {27'd0, count}, 32'd3);
    rd = 1'b1;
    for (int k = 0; k < 5; k++) step();
    rd = 1'b0;
    step();
    chk("long_count", {27'd0, count}, 32'd2);
    pop_byte(8'h02);
    pop_byte(8'h03);
    chk("long_empty", {31'd0, rdy}, 32'd0);

    // Simultaneous push and pop at full
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
    chk("full_count", {27'd0, count}, 32'd16);
    rxrdy = 1'b1;
    rxdata = 8'h77;
    rd = 1'b1;
    step();
    chk("sim_count",  {27'd0, count},  32'd16);
    chk("sim_ovf",    {31'd0, ovf},    32'd0);
    chk("sim_rxdone", {31'd0, rxdone}, 32'd1);
    chk("sim_head",   {24'd0, data},   32'h21);
    rxrdy = 1'b0;
    rd = 1'b0;
    step();
    step();
    for (int i = 1; i < 16; i++) pop_byte(8'h20 + 8'(i));
    chk("sim_last_count", {27'd0, count}, 32'd1);
    pop_byte(8'h77);
    chk("sim_empty", {27'd0, count}, 32'd0);

    // Wrap-around, 40 bytes in batches of 4
    for (int b = 0; b < 10; b++) begin
      for (int j = 0; j < 4; j++) push_byte(8'((b * 4 + j) ^ 8'h5A));
      chk("wrap_batch_count", {27'd0, count}, 32'd4);
      for (int j = 0; j < 4; j++) pop_byte(8'((b * 4 + j) ^ 8'h5A));
    end
    chk("wrap_ovf",   {31'd0, ovf},   32'd0);
    chk("wrap_count", {27'd0, count}, 32'd0);

    // Reset while waiting for receiver to drop rxrdy
    push_byte(8'h11);
    rxrdy = 1'b1;
    rxdata = 8'h99;
    step();
    chk("rw_capture_count", {27'd0, count}, 32'd2);
    step();
    chk("rw_wait_rxdone", {31'd0, rxdone}, 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("rw_count",  {27'd0, count}, 32'd0);
    chk("rw_rdy",    {31'd0, rdy},   32'd0);
    chk("rw_ovf",    {31'd0, ovf},   32'd0);
    chk("rw_data",   {24'd0, data},  32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("rw_recapture_count",  {27'd0, count},  32'd1);
    chk("rw_recapture_data",   {24'd0, data},   32'h99);
    chk("rw_recapture_rxdone", {31'd0, rxdone}, 32'd1);
    rxrdy = 1'b0;
    step();
    step();
    pop_byte(8'h99);
    chk("rw_final_count", {27'd0, count}, 32'd0);

    chk("rxdone_single_cycle", {31'd0, dbl_pulse}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
